// File: rtl/epu_axi_slave_if.sv
// AXI4 slave-port bundle between the interconnect and the EPU front-end.
// The slave modport is the EPU side; master is the interconnect side.
interface epu_axi_slave_if #(
   parameter int ID_BITS   = 8,
   parameter int DATA_BITS = 32
) ();
   logic [ID_BITS-1:0]   AWID;
   logic [31:0]          AWADDR;
   logic [3:0]           AWLEN;
   logic [2:0]           AWSIZE;
   logic [1:0]           AWBURST;
   logic                 AWVALID;
   logic                 AWREADY;
   logic [DATA_BITS-1:0] WDATA;
   logic [3:0]           WSTRB;
   logic                 WLAST;
   logic                 WVALID;
   logic                 WREADY;
   logic [ID_BITS-1:0]   BID;
   logic [1:0]           BRESP;
   logic                 BVALID;
   logic                 BREADY;
   logic [ID_BITS-1:0]   ARID;
   logic [31:0]          ARADDR;
   logic [3:0]           ARLEN;
   logic [2:0]           ARSIZE;
   logic [1:0]           ARBURST;
   logic                 ARVALID;
   logic                 ARREADY;
   logic [ID_BITS-1:0]   RID;
   logic [DATA_BITS-1:0] RDATA;
   logic [1:0]           RRESP;
   logic                 RLAST;
   logic                 RVALID;
   logic                 RREADY;

   modport slave (
      input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
      output AWREADY,
      input  WDATA, WSTRB, WLAST, WVALID,
      output WREADY,
      output BID, BRESP, BVALID,
      input  BREADY,
      input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
      output ARREADY,
      output RID, RDATA, RRESP, RLAST, RVALID,
      input  RREADY
   );

   modport master (
      output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
      input  AWREADY,
      output WDATA, WSTRB, WLAST, WVALID,
      input  WREADY,
      input  BID, BRESP, BVALID,
      output BREADY,
      output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
      input  ARREADY,
      input  RID, RDATA, RRESP, RLAST, RVALID,
      output RREADY
   );
endinterface

// File: rtl/epu_axi_slave.sv
// AXI4 slave front-end for the EPU: serialises one burst at a time
// onto the EPU control bundle and returns read data on R.
module epu_axi_slave #(
   parameter int EPU_ADDR_BITS = 16,
   parameter int DATA_BITS     = 32,
   parameter int ID_BITS       = 8
) (
   input  logic                     ACLK,
   input  logic                     ARESETn,
   epu_axi_slave_if.slave           axi,
   input  logic [DATA_BITS-1:0]     epu_rdata,
   output logic                     OE,
   output logic                     CS,
   output logic                     arhns,
   output logic                     awhns,
   output logic                     whns,
   output logic                     rhns,
   output logic                     rdfin,
   output logic                     wrfin,
   output logic [EPU_ADDR_BITS-1:0] addr,
   output logic [DATA_BITS-1:0]     wdata
);

   typedef enum logic [2:0] {
      IDLE,
      RFETCH,
      RVAL,
      WDATA,
      WRESP
   } state_e;

   state_e                   state_q;
   logic [ID_BITS-1:0]       id_q;
   logic [EPU_ADDR_BITS-1:0] addr_q;
   logic [3:0]               len_q;
   logic [3:0]               cnt_q;
   logic                     err_q;

   logic st_idle;
   logic st_rf;
   logic st_rv;
   logic st_wd;
   logic st_wr;
   logic last;
   logic aw_hs;
   logic ar_hs;
   logic w_hs;
   logic r_hs;
   logic b_hs;
   logic unused_sig;

   assign st_idle = (state_q == IDLE);
   assign st_rf   = (state_q == RFETCH);
   assign st_rv   = (state_q == RVAL);
   assign st_wd   = (state_q == WDATA);
   assign st_wr   = (state_q == WRESP);
   assign last    = (cnt_q == len_q);

   // Ready is gated by reset so the whole bundle reads 0 while held.
   assign axi.AWREADY = st_idle & ARESETn;
   assign axi.ARREADY = st_idle & ARESETn & ~axi.AWVALID;

   assign aw_hs = axi.AWREADY & axi.AWVALID;
   assign ar_hs = axi.ARREADY & axi.ARVALID;
   assign w_hs  = axi.WREADY & axi.WVALID;
   assign r_hs  = axi.RVALID & axi.RREADY;
   assign b_hs  = axi.BVALID & axi.BREADY;

   assign axi.WREADY = st_wd;

   assign axi.RVALID = st_rv;
   assign axi.RDATA  = st_rv ? epu_rdata : '0;
   assign axi.RID    = st_rv ? id_q : '0;
   assign axi.RRESP  = 2'b00;
   assign axi.RLAST  = st_rv & last;

   assign axi.BVALID = st_wr;
   assign axi.BID    = st_wr ? id_q : '0;
   assign axi.BRESP  = (st_wr & err_q) ? 2'b10 : 2'b00;

   assign OE    = st_rf | st_rv;
   assign CS    = ~st_idle | aw_hs | ar_hs;
   assign addr  = (st_rf | st_rv | st_wd) ? addr_q : '0;
   assign wdata = st_wd ? axi.WDATA : '0;

   assign arhns = ar_hs;
   assign awhns = aw_hs;
   assign whns  = w_hs;
   assign rhns  = r_hs;
   assign rdfin = r_hs & last;
   assign wrfin = b_hs;

   // Size, burst type, strobes and upper address bits are not decoded.
   assign unused_sig = ^{axi.AWSIZE, axi.AWBURST, axi.ARSIZE,
                         axi.ARBURST, axi.WSTRB, axi.AWADDR,
                         axi.ARADDR};

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q <= IDLE;
         id_q    <= '0;
         addr_q  <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (aw_hs) begin
                  id_q    <= axi.AWID;
                  addr_q  <= axi.AWADDR[EPU_ADDR_BITS-1:0];
                  len_q   <= axi.AWLEN;
                  cnt_q   <= '0;
                  err_q   <= 1'b0;
                  state_q <= WDATA;
               end else if (ar_hs) begin
                  id_q    <= axi.ARID;
                  addr_q  <= axi.ARADDR[EPU_ADDR_BITS-1:0];
                  len_q   <= axi.ARLEN;
                  cnt_q   <= '0;
                  state_q <= RFETCH;
               end
            end
            RFETCH: state_q <= RVAL;
            RVAL: begin
               if (r_hs) begin
                  if (last) begin
                     state_q <= IDLE;
                  end else begin
                     addr_q  <= addr_q + EPU_ADDR_BITS'(4);
                     cnt_q   <= cnt_q + 4'd1;
                     state_q <= RFETCH;
                  end
               end
            end
            WDATA: begin
               if (w_hs) begin
                  // Beat count ends the burst; a WLAST mismatch is
                  // only reported back as SLVERR.
                  if (axi.WLAST != last) err_q <= 1'b1;
                  if (last) begin
                     state_q <= WRESP;
                  end else begin
                     addr_q <= addr_q + EPU_ADDR_BITS'(4);
                     cnt_q  <= cnt_q + 4'd1;
                  end
               end
            end
            WRESP: begin
               if (b_hs) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_epu_axi_slave.sv
// Scoreboard bench for epu_axi_slave: directed bursts push expected
// beats into queues, a negedge monitor pops and compares them.
module tb_epu_axi_slave;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   epu_axi_slave_if #(.ID_BITS(8), .DATA_BITS(32)) axi ();

   logic [31:0] epu_rdata;
   logic        OE, CS, arhns, awhns, whns, rhns, rdfin, wrfin;
   logic [15:0] addr;
   logic [31:0] wdata;

   epu_axi_slave #(
      .EPU_ADDR_BITS(16), .DATA_BITS(32), .ID_BITS(8)
   ) dut (
      .ACLK(clk), .ARESETn(rst_n), .axi(axi),
      .epu_rdata(epu_rdata),
      .OE(OE), .CS(CS), .arhns(arhns), .awhns(awhns),
      .whns(whns), .rhns(rhns), .rdfin(rdfin), .wrfin(wrfin),
      .addr(addr), .wdata(wdata)
   );

   function automatic logic [31:0] mem_f(input logic [15:0] a);
      case (a)
         16'h0010: mem_f = 32'hDEADBEEF;
         16'h0200: mem_f = 32'h11111111;
         16'h0204: mem_f = 32'h22222222;
         16'h0208: mem_f = 32'h33333333;
         default:  mem_f = {16'hA5A5, a};
      endcase
   endfunction

   always @(posedge clk or negedge rst_n)
      if (!rst_n) epu_rdata <= '0;
      else if (OE && CS) epu_rdata <= mem_f(addr);

   typedef struct packed {
      logic [7:0]  id;
      logic [31:0] d;
      logic        last;
      logic [15:0] a;
   } r_t;
   typedef struct packed {
      logic [15:0] a;
      logic [31:0] d;
   } w_t;
   typedef struct packed {
      logic [7:0] id;
      logic [1:0] resp;
   } b_t;

   r_t rq[$];
   w_t wq[$];
   b_t bq[$];

   int  errors = 0;
   int  checks = 0;
   logic wr_busy = 1'b0;
   logic saw_ar  = 1'b0;
   time t_wrfin  = 0;
   time t_arhns  = 0;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h",
                  name, act, exp);
      end
   endtask

   task automatic push_r(input logic [7:0] id, input logic [31:0] d,
                         input logic last, input logic [15:0] a);
      r_t e;
      e = '{id, d, last, a};
      rq.push_back(e);
   endtask

   task automatic push_w(input logic [15:0] a, input logic [31:0] d);
      w_t e;
      e = '{a, d};
      wq.push_back(e);
   endtask

   task automatic push_b(input logic [7:0] id, input logic [1:0] r);
      b_t e;
      e = '{id, r};
      bq.push_back(e);
   endtask

   // Monitor
   initial begin
      logic        stall_q;
      logic [31:0] pd;
      logic [15:0] pa;
      logic        pl;
      r_t re;
      w_t we;
      b_t be;
      stall_q = 1'b0;
      pd = '0;
      pa = '0;
      pl = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stall_q = 1'b0;
         end else begin
            if (stall_q && axi.RVALID) begin
               check("r_stable_data", axi.RDATA, pd);
               check("r_stable_addr", {16'h0, addr}, {16'h0, pa});
               check("r_stable_last", axi.RLAST, pl);
            end
            stall_q = axi.RVALID && !axi.RREADY;
            pd = axi.RDATA;
            pa = addr;
            pl = axi.RLAST;
            if (arhns) t_arhns = $time;
            if (wr_busy && axi.ARREADY) saw_ar = 1'b1;
            if (axi.RVALID && axi.RREADY) begin
               if (rq.size() == 0) begin
                  check("r_unexpected", 1, 0);
               end else begin
                  re = rq.pop_front();
                  check("rid", axi.RID, re.id);
                  check("rdata", axi.RDATA, re.d);
                  check("rlast", axi.RLAST, re.last);
                  check("rresp", axi.RRESP, 0);
                  check("r_addr", {16'h0, addr}, {16'h0, re.a});
                  check("r_oe_cs", {OE, CS}, 2'b11);
                  check("rhns", rhns, 1);
                  check("rdfin", rdfin, re.last);
               end
            end
            if (axi.WVALID && axi.WREADY) begin
               if (wq.size() == 0) begin
                  check("w_unexpected", 1, 0);
               end else begin
                  we = wq.pop_front();
                  check("w_addr", {16'h0, addr}, {16'h0, we.a});
                  check("w_data", wdata, we.d);
                  check("whns", {whns, CS}, 2'b11);
               end
            end
            if (axi.BVALID && axi.BREADY) begin
               if (bq.size() == 0) begin
                  check("b_unexpected", 1, 0);
               end else begin
                  be = bq.pop_front();
                  check("bid", axi.BID, be.id);
                  check("bresp", axi.BRESP, be.resp);
                  check("wrfin", wrfin, 1);
               end
               t_wrfin = $time;
               wr_busy = 1'b0;
            end
         end
      end
   end

   task automatic do_aw(input logic [7:0] id, input logic [31:0] a,
                        input logic [3:0] len);
      int n;
      axi.AWID = id;
      axi.AWADDR = a;
      axi.AWLEN = len;
      axi.AWSIZE = 3'd2;
      axi.AWBURST = 2'd1;
      axi.AWVALID = 1'b1;
      n = 0;
      @(negedge clk);
      while (!axi.AWREADY && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!axi.AWREADY) check("aw_timeout", 1, 0);
      else check("awhns", {awhns, CS}, 2'b11);
      @(posedge clk);
      #1 axi.AWVALID = 1'b0;
   endtask

   task automatic do_ar(input logic [7:0] id, input logic [31:0] a,
                        input logic [3:0] len);
      int n;
      axi.ARID = id;
      axi.ARADDR = a;
      axi.ARLEN = len;
      axi.ARSIZE = 3'd2;
      axi.ARBURST = 2'd1;
      axi.ARVALID = 1'b1;
      n = 0;
      @(negedge clk);
      while (!axi.ARREADY && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!axi.ARREADY) check("ar_timeout", 1, 0);
      else check("arhns", {arhns, CS}, 2'b11);
      @(posedge clk);
      #1 axi.ARVALID = 1'b0;
   endtask

   task automatic do_write(input logic [7:0] id, input logic [31:0] a,
                           input logic [3:0] len, input logic [31:0] base,
                           input logic [15:0] lastmask);
      int n;
      do_aw(id, a, len);
      for (int b = 0; b <= int'(len); b++) begin
         axi.WDATA = base + b;
         axi.WLAST = lastmask[b];
         axi.WVALID = 1'b1;
         n = 0;
         @(negedge clk);
         while (!axi.WREADY && n < 200) begin
            @(negedge clk);
            n++;
         end
         if (!axi.WREADY) check("w_timeout", 1, 0);
         @(posedge clk);
         #1;
      end
      axi.WVALID = 1'b0;
      axi.WLAST = 1'b0;
      @(negedge clk);
      check("bvalid_next", axi.BVALID, 1);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while ((rq.size() + wq.size() + bq.size()) != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if ((rq.size() + wq.size() + bq.size()) != 0) begin
         check("drain_timeout", 1, 0);
         rq.delete();
         wq.delete();
         bq.delete();
      end
      @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ready"}, {axi.AWREADY, axi.ARREADY, axi.WREADY}, 0);
      check({tag, "_valid"}, {axi.RVALID, axi.BVALID, axi.RLAST}, 0);
      check({tag, "_rdata"}, axi.RDATA, 0);
      check({tag, "_ids"}, {axi.RID, axi.BID, axi.BRESP}, 0);
      check({tag, "_ctl"}, {OE, CS, arhns, awhns, whns, rhns,
                            rdfin, wrfin}, 0);
      check({tag, "_addr"}, {16'h0, addr}, 0);
      check({tag, "_wdata"}, wdata, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      axi.AWID = '0;   axi.AWADDR = '0; axi.AWLEN = '0;
      axi.AWSIZE = '0; axi.AWBURST = '0; axi.AWVALID = 1'b0;
      axi.WDATA = '0;  axi.WSTRB = 4'hF; axi.WLAST = 1'b0;
      axi.WVALID = 1'b0;
      axi.BREADY = 1'b1;
      axi.ARID = '0;   axi.ARADDR = '0; axi.ARLEN = '0;
      axi.ARSIZE = '0; axi.ARBURST = '0; axi.ARVALID = 1'b0;
      axi.RREADY = 1'b1;

      #1 check_all_zero("reset");
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1 check("idle_ready", {axi.AWREADY, axi.ARREADY}, 2'b11);
      check("idle_cs", CS, 0);

      // Single read
      push_r(8'h11, 32'hDEADBEEF, 1'b1, 16'h0010);
      do_ar(8'h11, 32'h0000_0010, 4'd0);
      check("rfetch_oe", {OE, CS, axi.RVALID}, 3'b110);
      check("rfetch_addr", {16'h0, addr}, 32'h0010);
      wait_done();
      check("post_read_cs", {CS, OE, axi.RVALID}, 0);

      // 4-beat write
      push_w(16'h0100, 32'hA000_0000);
      push_w(16'h0104, 32'hA000_0001);
      push_w(16'h0108, 32'hA000_0002);
      push_w(16'h010C, 32'hA000_0003);
      push_b(8'h22, 2'b00);
      do_write(8'h22, 32'h0000_0100, 4'd3, 32'hA000_0000, 16'h0008);
      wait_done();

      // Simultaneous AW and AR: write first, then the read
      push_w(16'h0040, 32'hB000_0000);
      push_w(16'h0044, 32'hB000_0001);
      push_b(8'h33, 2'b00);
      push_r(8'h5A, 32'hDEADBEEF, 1'b1, 16'h0010);
      wr_busy = 1'b1;
      saw_ar = 1'b0;
      fork
         do_write(8'h33, 32'h0000_0040, 4'd1, 32'hB000_0000, 16'h0002);
         do_ar(8'h5A, 32'h0000_0010, 4'd0);
      join
      wait_done();
      check("ar_blocked", saw_ar, 0);
      check("wr_before_rd", (t_arhns > t_wrfin), 1);

      // Read burst with a 3-cycle stall on beat 1
      push_r(8'h77, 32'h11111111, 1'b0, 16'h0200);
      push_r(8'h77, 32'h22222222, 1'b0, 16'h0204);
      push_r(8'h77, 32'h33333333, 1'b1, 16'h0208);
      fork
         do_ar(8'h77, 32'h0000_0200, 4'd2);
         begin
            n = 0;
            @(negedge clk);
            while (!(axi.RVALID && axi.RREADY) && n < 100) begin
               @(negedge clk);
               n++;
            end
            @(posedge clk);
            #1 axi.RREADY = 1'b0;
            n = 0;
            @(negedge clk);
            while (!axi.RVALID && n < 100) begin
               @(negedge clk);
               n++;
            end
            if (!axi.RVALID) check("stall_timeout", 1, 0);
            repeat (3) @(posedge clk);
            #1 axi.RREADY = 1'b1;
         end
      join
      wait_done();

      // WLAST early on beat 0 -> both beats taken, SLVERR
      push_w(16'h0020, 32'hD000_0000);
      push_w(16'h0024, 32'hD000_0001);
      push_b(8'h44, 2'b10);
      do_write(8'h44, 32'h0000_0020, 4'd1, 32'hD000_0000, 16'h0001);
      wait_done();

      // Reset asserted while in RVAL
      axi.RREADY = 1'b0;
      do_ar(8'h88, 32'h0000_0200, 4'd2);
      n = 0;
      @(negedge clk);
      while (!axi.RVALID && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("rval_reached", axi.RVALID, 1);
      #2 rst_n = 1'b0;
      #1 check_all_zero("midreset");
      axi.RREADY = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      push_w(16'h0300, 32'hC0FF_EE00);
      push_b(8'h99, 2'b00);
      do_write(8'h99, 32'h0000_0300, 4'd0, 32'hC0FF_EE00, 16'h0001);
      wait_done();
      check("final_idle", {axi.AWREADY, CS}, 2'b10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
